rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one 8-input priority-encoded resource (index D[2:0] plus valid flag) among 8 requesters.
- Samples a request vector, grants exactly one requester at a time and holds the grant until the owner releases it.
- Then rotates priority so that no requester starves.
- Sits in front of the 8-to-3 encoder datapath and drives its one-hot input and select index.

---
 rtl/rr_arbiter8.sv | 156 +++++++++++++++
 tb/tb_rr_arbiter8.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- round-robin arbiter sharing one 8-input resource among
// eight requesters. A grant is held until the owner releases it. Priority
// then rotates to the requester after the owner, so no requester starves.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      level-sensitive request vector, bit k = requester k
//   done     single-cycle release pulse from the current owner
//   gnt      one-hot grant, all-zero when idle
//   gnt_id   binary index of the granted requester (valid with gnt_val)
//   gnt_val  high while a grant is active
//   timeout  one-cycle pulse when a grant is forcibly revoked
//
// Build option: define ARB_TIMEOUT_EN to add the hold counter that revokes
// a grant after MAX_HOLD cycles. Without it, timeout is constant zero.

module rr_arbiter8 #(
  parameter int NREQ     = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_val,
  output logic            timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;

  logic [NREQ-1:0] owner_oh;
  logic [IDW-1:0]  rot_ptr;
  logic [IDW:0]    pick_idle;
  logic [IDW:0]    pick_rot;
  logic            user_rel;
  logic            expire;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]      hold_q, hold_d;
  logic            timeout_q, timeout_d;
`endif

  // First set bit of r searching upward from start, wrapping at the top.
  // Result is {found, index}. Scanning downward in offset lets the smallest
  // offset overwrite any later hit, so no early exit is needed. The index
  // wraps naturally because NREQ == 2**IDW.
  function automatic logic [IDW:0] pick(input logic [NREQ-1:0] r,
                                        input logic [IDW-1:0]  start);
    logic [IDW-1:0] idx;
    logic [IDW:0]   res;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = start + IDW'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // State register. Reset clears everything, so arbitration restarts with
  // requester 0 at highest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next-state logic. On a release, the pointer moves past the owner.
  // Re-arbitration happens on the same edge with the owner masked out, so
  // a handover never leaves an idle bubble. A voluntary release lets a
  // lone owner win again. A timeout never does.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    owner_oh  = NREQ'(1) << id_q;
    rot_ptr   = id_q + IDW'(1);
    pick_idle = pick(req, ptr_q);
    pick_rot  = pick(req & ~owner_oh, rot_ptr);
    user_rel  = done || !req[id_q];
`ifdef ARB_TIMEOUT_EN
    expire    = !user_rel && (hold_q == 8'(MAX_HOLD - 1));
    hold_d    = '0;
    timeout_d = 1'b0;
`else
    expire    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_idle[IDW]) begin
          state_d = GRANT;
          id_d    = pick_idle[IDW-1:0];
        end
      end
      GRANT: begin
        if (user_rel || expire) begin
          ptr_d = rot_ptr;
          if (pick_rot[IDW]) begin
            id_d = pick_rot[IDW-1:0];
          end else if (req[id_q] && !expire) begin
            id_d = id_q;
          end else begin
            state_d = IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          timeout_d = expire;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. These are pure functions of registers, so the outputs
  // change only on clock edges or asynchronously on reset.
  always_comb begin
    gnt_val = (state_q == GRANT);
    gnt     = gnt_val ? (NREQ'(1) << id_q) : '0;
    gnt_id  = gnt_val ? id_q : '0;
  end

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // MAX_HOLD is limited to 1..255, so this is always zero. Writing it in
  // terms of the parameter keeps MAX_HOLD referenced in this build.
  assign timeout = (MAX_HOLD < 1);
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8 -- scoreboard bench for rr_arbiter8.
// The driver applies req/done/rst_n on the falling edge. It advances a
// behavioural model of the arbitration rules and queues the outputs that
// the model expects after the next rising edge. A separate monitor samples
// the DUT just after each rising edge, pops one entry and compares.
// If ARB_TIMEOUT_EN is defined, the model also applies the hold limit.

module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       val;
    logic       to;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'hFF;
  logic       done  = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_val;
  logic       timeout;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Model state: current owner (-1 when idle), rotating start position,
  // and the number of cycles the current grant has been visible.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;

  rr_arbiter8 #(.NREQ(8), .IDW(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_val (gnt_val),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Finds the nearest requester at or after position start, wrapping around.
  function automatic int first_from(input logic [7:0] r, input int start);
    for (int i = 0; i < 8; i++) begin
      if (r[(start + i) % 8]) return (start + i) % 8;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advances the model by one rising edge with the given inputs, then
  // queues the outputs expected after that edge.
  task automatic modelStep(input logic [7:0] r, input logic d, input logic rn);
    exp_t e;
    bit   rel;
    bit   expired;
    int   cand;
    expired = 1'b0;
    if (!rn) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      cand = first_from(r, m_ptr);
      if (cand >= 0) begin
        m_owner = cand;
        m_held  = 0;
      end
    end else begin
      m_held++;
      rel     = d || !r[m_owner];
      expired = TIMEOUT_ON && !rel && (m_held == MAX_HOLD);
      if (rel || expired) begin
        m_ptr = (m_owner + 1) % 8;
        cand  = first_from(r & ~(8'h01 << m_owner), m_ptr);
        if (cand >= 0) begin
          m_owner = cand;
          m_held  = 0;
        end else if (r[m_owner] && !expired) begin
          m_held = 0;
        end else begin
          m_owner = -1;
        end
      end
    end
    e.val = (m_owner >= 0);
    e.gnt = e.val ? (8'h01 << m_owner) : 8'h00;
    e.id  = e.val ? 3'(m_owner) : 3'd0;
    e.to  = expired;
    exp_q.push_back(e);
  endtask

  // Drives one cycle of stimulus on the falling edge. If reset is asserted
  // while running, the outputs must clear at once, without a clock edge.
  task automatic applyStimulus(input logic [7:0] r, input logic d, input logic rn);
    @(negedge clk);
    req  = r;
    done = d;
    if (!rn && rst_n) begin
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_gnt", gnt, 8'h00);
      checkOutput("async_rst_val", {7'b0, gnt_val}, 8'h00);
      checkOutput("async_rst_timeout", {7'b0, timeout}, 8'h00);
    end
    rst_n = rn;
    vectors++;
    modelStep(r, d, rn);
  endtask

  // Monitor: samples the DUT just after each rising edge against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("gnt", gnt, e.gnt);
        checkOutput("gnt_val", {7'b0, gnt_val}, {7'b0, e.val});
        checkOutput("timeout", {7'b0, timeout}, {7'b0, e.to});
        if (e.val) checkOutput("gnt_id", {5'b0, gnt_id}, {5'b0, e.id});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] r;
    int         mode;

    // Reset held with every requester active.
    repeat (2) applyStimulus(8'hFF, 1'b0, 1'b0);

    // Rotation: all request, owner releases after three cycles.
    for (int i = 0; i < 26; i++) applyStimulus(8'hFF, (i % 3 == 0) && (i > 0), 1'b1);

    // Wrap and skip: id 6 owns, then 0 and 2 follow.
    repeat (2) applyStimulus(8'h00, 1'b0, 1'b1);
    repeat (2) applyStimulus(8'h40, 1'b0, 1'b1);
    applyStimulus(8'h45, 1'b1, 1'b1);
    repeat (2) applyStimulus(8'h45, 1'b0, 1'b1);
    applyStimulus(8'h45, 1'b1, 1'b1);
    repeat (2) applyStimulus(8'h45, 1'b0, 1'b1);

    // Withdrawal by the owner, then a fresh request.
    repeat (2) applyStimulus(8'h00, 1'b0, 1'b1);
    repeat (3) applyStimulus(8'h08, 1'b0, 1'b1);
    repeat (2) applyStimulus(8'h00, 1'b0, 1'b1);
    repeat (2) applyStimulus(8'h01, 1'b0, 1'b1);

    // Sole requester re-granted across done.
    repeat (2) applyStimulus(8'h10, 1'b0, 1'b1);
    applyStimulus(8'h10, 1'b1, 1'b1);
    repeat (2) applyStimulus(8'h10, 1'b0, 1'b1);
    applyStimulus(8'h10, 1'b1, 1'b1);
    applyStimulus(8'h10, 1'b0, 1'b1);

    // done while idle is ignored.
    repeat (2) applyStimulus(8'h00, 1'b1, 1'b1);

    // done and owner withdrawal in the same cycle.
    repeat (2) applyStimulus(8'h20, 1'b0, 1'b1);
    applyStimulus(8'h0A, 1'b1, 1'b1);
    repeat (2) applyStimulus(8'h0A, 1'b0, 1'b1);
    applyStimulus(8'h0A, 1'b1, 1'b1);
    applyStimulus(8'h0A, 1'b0, 1'b1);

    // Reset mid-grant, then the hold-limit scenario from a clean pointer.
    applyStimulus(8'h03, 1'b0, 1'b1);
    applyStimulus(8'h03, 1'b0, 1'b0);
    repeat (8) applyStimulus(8'h03, 1'b0, 1'b1);
    repeat (8) applyStimulus(8'h01, 1'b0, 1'b1);

    // Randomized traffic: dense, sparse and single-bit request patterns.
    for (int i = 0; i < 400; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0)      r = 8'($urandom);
      else if (mode == 1) r = 8'($urandom & $urandom & $urandom);
      else                r = 8'h01 << $urandom_range(0, 7);
      applyStimulus(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0));
    end

    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drain", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
